intc_seq: RTL and testbench

Interrupt sequencer that sits directly upstream of the 64-word interrupt handler ROM: it latches interrupt requests, freezes the main fetch path, and drives the 6-bit handler ROM address. It watches the returned handler words for ERET and then restores the main PC. The ROM is split into four 16-word vector slots, one per IRQ line. Slot base is {vec, 4'b0000}.

---
 rtl/intc_pkg.sv | 26 ++
 rtl/intc_prio_enc.sv | 28 ++
 rtl/intc_seq.sv | 192 +++++++++++++++++++
 tb/tb_intc_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// ----------------------------------------------------------------------------
// intc_pkg
// Shared constants and types for the interrupt sequencer.
//   ERET_WORD  : handler-ROM word that ends a handler and restores the main PC
//   NUM_VEC    : number of IRQ lines / vector slots in the handler ROM
//   VEC_WORDS  : words per vector slot
//   state_t    : sequencer FSM encoding (IDLE/ENTER/RUN/EXIT)
// ----------------------------------------------------------------------------
package intc_pkg;

    localparam logic [31:0] ERET_WORD = 32'h42000018;

    localparam int NUM_VEC   = 4;
    localparam int VEC_WORDS = 16;
    localparam int VEC_W     = $clog2(NUM_VEC);
    localparam int OFF_W     = $clog2(VEC_WORDS);
    localparam int ADDR_W    = VEC_W + OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        RUN   = 2'd2,
        EXIT  = 2'd3
    } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// ----------------------------------------------------------------------------
// intc_prio_enc
// Purely combinational priority encoder. The lowest set request bit wins.
// Ports:
//   req   in  NUM_VEC  request bits (pending & mask)
//   vec   out VEC_W    index of the winning request (0 when none)
//   valid out 1        at least one request bit is set
// ----------------------------------------------------------------------------
module intc_prio_enc
    import intc_pkg::*;
(
    input  logic [NUM_VEC-1:0] req,
    output logic [VEC_W-1:0]   vec,
    output logic               valid
);

    always_comb begin
        vec   = '0;
        valid = |req;
        // Scan from the top down so the lowest index is the last to write.
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_seq.sv
// ----------------------------------------------------------------------------
// intc_seq
// Interrupt sequencer in front of a 64-word handler ROM (4 slots x 16 words).
// Latches rising edges on irq, freezes the main fetch path, walks the handler
// slot of the highest-priority (lowest index) eligible line, and on ERET (or
// on running off the end of the slot) strobes the saved return PC back.
//
// Optional feature: define INTC_MASK_EN to get a writable 4-bit mask
// register (reset 4'hF). Without it the mask is tied to all-enabled and
// mask_we / mask_wdata are ignored.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   irq         in   raw interrupt lines, rising-edge sensitive
//   cpu_pc      in   PC the CPU is fetching (captured as return PC)
//   cpu_adv     in   CPU consumed the current instruction
//   hdl_instr   in   handler ROM word at hdl_addr
//   mask_we     in   mask write strobe (INTC_MASK_EN only)
//   mask_wdata  in   mask write data, 1 = enabled (INTC_MASK_EN only)
//   hdl_addr    out  handler ROM address {vec, offset}
//   sel_intc    out  instruction mux select, 1 = handler ROM
//   cpu_stall   out  hold the main PC
//   pc_load     out  one-cycle strobe to load pc_load_val
//   pc_load_val out  saved return PC
//   cause       out  vector number in service
//   err         out  sticky slot-overrun flag
// ----------------------------------------------------------------------------
module intc_seq
    import intc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_VEC-1:0]  irq,
    input  logic [31:0]         cpu_pc,
    input  logic                cpu_adv,
    input  logic [31:0]         hdl_instr,
    input  logic                mask_we,
    input  logic [NUM_VEC-1:0]  mask_wdata,
    output logic [ADDR_W-1:0]   hdl_addr,
    output logic                sel_intc,
    output logic                cpu_stall,
    output logic                pc_load,
    output logic [31:0]         pc_load_val,
    output logic [VEC_W-1:0]    cause,
    output logic                err
);

    state_t               state_reg, state_next;
    logic [NUM_VEC-1:0]   irq_q_reg;
    logic [NUM_VEC-1:0]   pending_reg, pending_next;
    logic [NUM_VEC-1:0]   pend_set, pend_clr;
    logic [NUM_VEC-1:0]   mask;
    logic [NUM_VEC-1:0]   eligible;
    logic [VEC_W-1:0]     vec_reg, vec_next;
    logic [31:0]          epc_reg, epc_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic                 err_reg, err_next;
    logic [VEC_W-1:0]     enc_vec;
    logic                 enc_valid;

    // ------------------------------------------------------------------
    // Mask
    // ------------------------------------------------------------------
`ifdef INTC_MASK_EN
    logic [NUM_VEC-1:0] mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '1;
        end else if (mask_we) begin
            mask_reg <= mask_wdata;
        end
    end

    assign mask = mask_reg;
`else
    logic unused_mask_inputs;
    assign unused_mask_inputs = &{1'b0, mask_we, mask_wdata};
    assign mask = '1;
`endif

    // ------------------------------------------------------------------
    // Edge detect and pending bits. A new edge on the same cycle as the
    // handler exit for that line must survive, so set has priority.
    // ------------------------------------------------------------------
    assign pend_set = irq & ~irq_q_reg;

    for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_pending
        assign pending_next[gi] = pend_set[gi] | (pending_reg[gi] & ~pend_clr[gi]);
    end

    // Masked lines stay pending and are picked up once re-enabled.
    assign eligible = pending_reg & mask;

    intc_prio_enc u_prio_enc (
        .req   (eligible),
        .vec   (enc_vec),
        .valid (enc_valid)
    );

    // ------------------------------------------------------------------
    // FSM: next state, datapath next values and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        epc_next   = epc_reg;
        addr_next  = addr_reg;
        err_next   = err_reg;
        pend_clr   = '0;
        sel_intc   = 1'b0;
        cpu_stall  = 1'b0;
        pc_load    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (enc_valid) begin
                    vec_next   = enc_vec;
                    state_next = ENTER;
                end
            end

            ENTER: begin
                cpu_stall  = 1'b1;
                epc_next   = cpu_pc;
                addr_next  = {vec_reg, {OFF_W{1'b0}}};
                state_next = RUN;
            end

            RUN: begin
                sel_intc  = 1'b1;
                cpu_stall = 1'b1;
                if (cpu_adv) begin
                    if (hdl_instr == ERET_WORD) begin
                        pend_clr[vec_reg] = 1'b1;
                        state_next        = EXIT;
                    end else if (addr_reg[OFF_W-1:0] == {OFF_W{1'b1}}) begin
                        // Last word of the slot was not ERET: force a return
                        // rather than fetch from the neighbouring slot.
                        err_next          = 1'b1;
                        pend_clr[vec_reg] = 1'b1;
                        state_next        = EXIT;
                    end else begin
                        // Only the offset field advances; the slot is fixed.
                        addr_next = {addr_reg[ADDR_W-1:OFF_W],
                                     addr_reg[OFF_W-1:0] + OFF_W'(1)};
                    end
                end
            end

            EXIT: begin
                cpu_stall  = 1'b1;
                pc_load    = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            irq_q_reg   <= '0;   // a line held high across reset re-triggers
            pending_reg <= '0;
            vec_reg     <= '0;
            epc_reg     <= '0;
            addr_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            irq_q_reg   <= irq;
            pending_reg <= pending_next;
            vec_reg     <= vec_next;
            epc_reg     <= epc_next;
            addr_reg    <= addr_next;
            err_reg     <= err_next;
        end
    end

    assign hdl_addr    = addr_reg;
    assign pc_load_val = epc_reg;
    assign cause       = vec_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_intc_seq.sv
// ----------------------------------------------------------------------------
// tb_intc_seq
// Directed vector table for single-IRQ and priority sequences, followed by
// hand-written sequences for stall, slot overrun, re-arm, reset and mask.
// Build with INTC_MASK_EN defined to exercise the mask register.
// ----------------------------------------------------------------------------
module tb_intc_seq;

    localparam logic [31:0] ERET = 32'h42000018;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic [31:0] cpu_pc;
    logic        cpu_adv;
    logic [31:0] hdl_instr;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [5:0]  hdl_addr;
    logic        sel_intc;
    logic        cpu_stall;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [1:0]  cause;
    logic        err;

    logic [31:0] rom [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Handler ROM model: combinational read at the DUT address.
    assign hdl_instr = rom[hdl_addr];

    intc_seq dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .cpu_pc      (cpu_pc),
        .cpu_adv     (cpu_adv),
        .hdl_instr   (hdl_instr),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .hdl_addr    (hdl_addr),
        .sel_intc    (sel_intc),
        .cpu_stall   (cpu_stall),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .cause       (cause),
        .err         (err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic [31:0] pc;
        logic        adv;
        logic [5:0]  e_addr;
        logic        e_sel;
        logic        e_stall;
        logic        e_pl;
        logic [31:0] e_plv;
        logic [1:0]  e_cause;
        logic        e_err;
        logic        chk_addr;
        logic        chk_cause;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] i, logic [31:0] pc, logic adv,
                                logic [5:0] a, logic s, logic st, logic pl,
                                logic [31:0] plv, logic [1:0] c, logic e,
                                logic ca, logic cc);
        vec_t v;
        v.rst = r; v.irq = i; v.pc = pc; v.adv = adv;
        v.e_addr = a; v.e_sel = s; v.e_stall = st; v.e_pl = pl;
        v.e_plv = plv; v.e_cause = c; v.e_err = e;
        v.chk_addr = ca; v.chk_cause = cc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input string name, input int budget);
        int n = 0;
        while (sel_intc !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(sel_intc), 32'd1);
    endtask

    task automatic wait_pl(input string name, input int budget);
        int n = 0;
        while (pc_load !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(pc_load), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = NOP;
        rom[6'h23] = ERET;
        rom[6'h10] = ERET;
        rom[6'h30] = ERET;

        rst = 1'b1; irq = '0; cpu_pc = '0; cpu_adv = 1'b0;
        mask_we = 1'b0; mask_wdata = 4'hF;

        //        rst irq   pc        adv addr  sel st pl plv       c  e  ca cc
        // reset
        tbl.push_back(mk(1, 4'h0, 32'h00, 0, 6'h00, 0, 0, 0, 32'h00,  0, 0, 1, 1));
        // single IRQ on line 2, ERET at 0x23
        tbl.push_back(mk(0, 4'h4, 32'h40, 1, 6'h00, 0, 0, 0, 32'h00,  0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h40, 1, 6'h00, 0, 1, 0, 32'h00,  2, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 32'h40, 1, 6'h20, 1, 1, 0, 32'h40,  2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h44, 1, 6'h21, 1, 1, 0, 32'h40,  2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h44, 1, 6'h22, 1, 1, 0, 32'h40,  2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h44, 1, 6'h23, 1, 1, 0, 32'h40,  2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h44, 1, 6'h23, 0, 1, 1, 32'h40,  2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h44, 1, 6'h00, 0, 0, 0, 32'h40,  0, 0, 0, 0));
        // lines 3 and 1 together: 1 first, 3 right after
        tbl.push_back(mk(0, 4'hA, 32'h100, 1, 6'h00, 0, 0, 0, 32'h40,  0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 32'h100, 1, 6'h00, 0, 1, 0, 32'h40,  1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 32'h100, 1, 6'h10, 1, 1, 0, 32'h100, 1, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h104, 1, 6'h10, 0, 1, 1, 32'h100, 1, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h104, 1, 6'h00, 0, 0, 0, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 32'h200, 1, 6'h00, 0, 1, 0, 32'h100, 3, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 32'h200, 1, 6'h30, 1, 1, 0, 32'h200, 3, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h204, 1, 6'h30, 0, 1, 1, 32'h200, 3, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 32'h204, 1, 6'h00, 0, 0, 0, 32'h200, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; irq = tbl[i].irq; cpu_pc = tbl[i].pc; cpu_adv = tbl[i].adv;
            cyc();
            chk($sformatf("row%0d_sel", i),   32'(sel_intc),  32'(tbl[i].e_sel));
            chk($sformatf("row%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d_pl", i),    32'(pc_load),   32'(tbl[i].e_pl));
            chk($sformatf("row%0d_plv", i),   pc_load_val,    tbl[i].e_plv);
            chk($sformatf("row%0d_err", i),   32'(err),       32'(tbl[i].e_err));
            if (tbl[i].chk_addr)
                chk($sformatf("row%0d_addr", i), 32'(hdl_addr), 32'(tbl[i].e_addr));
            if (tbl[i].chk_cause)
                chk($sformatf("row%0d_cause", i), 32'(cause), 32'(tbl[i].e_cause));
            $display("row %0d: addr=%h sel=%b stall=%b pl=%b plv=%h cause=%0d err=%b",
                     i, hdl_addr, sel_intc, cpu_stall, pc_load, pc_load_val, cause, err);
        end

        // ---- stall: cpu_adv low for 3 cycles in RUN ----
        cpu_pc = 32'h300; cpu_adv = 1'b1;
        irq = 4'h4; cyc(); irq = 4'h0;
        wait_run("stall_enter", 6);
        chk("stall_addr0", 32'(hdl_addr), 32'h20);
        cpu_adv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("stall_hold%0d_addr", k), 32'(hdl_addr), 32'h20);
            chk($sformatf("stall_hold%0d_sel", k), 32'(sel_intc), 32'd1);
            chk($sformatf("stall_hold%0d_pl", k), 32'(pc_load), 32'd0);
        end
        cpu_adv = 1'b1;
        cyc();
        chk("stall_resume_addr", 32'(hdl_addr), 32'h21);
        cyc(); cyc(); cyc();
        chk("stall_exit_pl", 32'(pc_load), 32'd1);
        chk("stall_exit_plv", pc_load_val, 32'h300);
        cyc();
        chk("stall_idle", 32'(cpu_stall), 32'd0);
        $display("stall sequence: addr=%h plv=%h", hdl_addr, pc_load_val);

        // ---- slot overrun on vector 0 (no ERET in slot 0) ----
        irq = 4'h1; cyc(); irq = 4'h0;
        wait_run("ovr_enter", 6);
        chk("ovr_err_before", 32'(err), 32'd0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovr_addr%0d", k), 32'(hdl_addr), 32'(k));
            cyc();
        end
        chk("ovr_exit_pl", 32'(pc_load), 32'd1);
        chk("ovr_err", 32'(err), 32'd1);
        cyc();
        chk("ovr_idle", 32'(cpu_stall), 32'd0);
        chk("ovr_err_sticky", 32'(err), 32'd1);
        $display("overrun sequence: err=%b", err);

        // ---- re-arm: irq[0] edge on the ERET cycle of vector 0 ----
        rom[6'h02] = ERET;
        irq = 4'h1; cyc(); irq = 4'h0;
        wait_run("rearm_enter", 6);
        cyc(); cyc();
        chk("rearm_eret_addr", 32'(hdl_addr), 32'h02);
        irq = 4'h1;
        cyc();
        chk("rearm_exit_pl", 32'(pc_load), 32'd1);
        irq = 4'h0;
        cyc();
        chk("rearm_idle", 32'(cpu_stall), 32'd0);
        cyc();
        chk("rearm_reenter_stall", 32'(cpu_stall), 32'd1);
        chk("rearm_reenter_cause", 32'(cause), 32'd0);
        cyc();
        chk("rearm_run_sel", 32'(sel_intc), 32'd1);
        chk("rearm_run_addr", 32'(hdl_addr), 32'h00);
        wait_pl("rearm_second_exit", 8);
        cyc();
        chk("rearm_err_sticky", 32'(err), 32'd1);
        $display("re-arm sequence: cause=%0d err=%b", cause, err);

        // ---- reset in RUN; pending lost, held line re-triggers once ----
        irq = 4'h2; cyc(); irq = 4'h0;
        wait_run("rst_enter", 6);
        chk("rst_cause1", 32'(cause), 32'd1);
        cpu_adv = 1'b0;
        irq = 4'hC; cyc();
        irq = 4'h4; rst = 1'b1; cyc();
        chk("rst_addr", 32'(hdl_addr), 32'h00);
        chk("rst_sel", 32'(sel_intc), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_pl", 32'(pc_load), 32'd0);
        chk("rst_plv", pc_load_val, 32'h0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0; cpu_adv = 1'b1; cpu_pc = 32'h500;
        wait_run("rst_held_edge", 6);
        chk("rst_held_cause", 32'(cause), 32'd2);
        chk("rst_held_addr", 32'(hdl_addr), 32'h20);
        wait_pl("rst_held_exit", 8);
        irq = 4'h0;
        cyc();
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                cyc();
                if (cpu_stall === 1'b1) seen++;
            end
            chk("rst_pending_lost", 32'(seen), 32'd0);
        end
        $display("reset sequence: cause=%0d err=%b", cause, err);

        // ---- mask: line 0 masked, then restored ----
        mask_we = 1'b1; mask_wdata = 4'hE; cyc(); mask_we = 1'b0;
        irq = 4'h1; cyc(); irq = 4'h0;
`ifdef INTC_MASK_EN
        begin
            int seen = 0;
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (cpu_stall === 1'b1) seen++;
            end
            chk("mask_blocked", 32'(seen), 32'd0);
        end
        mask_we = 1'b1; mask_wdata = 4'hF; cyc(); mask_we = 1'b0;
`endif
        wait_run("mask_entry", 6);
        chk("mask_cause", 32'(cause), 32'd0);
        chk("mask_addr", 32'(hdl_addr), 32'h00);
        wait_pl("mask_exit", 8);
        cyc();
        $display("mask sequence: cause=%0d", cause);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
